// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared width default and FSM state encoding
//
// Purpose : Common definitions for the shift-and-add multiplier slice.
// Contents: DEFAULT_DATA_WIDTH - operand width used when the top is not overridden
//           state_t            - control FSM states (IDLE/LOAD/CALC/DONE)
package shift_add_multiplier_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_shift_left_register.sv
// rtl/shift_add_multiplier_shift_left_register.sv - loadable left shifter for the multiplicand
//
// Purpose: Holds the multiplicand and doubles it every cycle it is not being loaded.
// Ports  : clk      in   rising-edge clock
//          reset_n  in   asynchronous active-low reset, clears the register
//          load_en  in   1 = load d_in, 0 = shift left with zero fill
//          d_in     in   WIDTH-bit load value
//          q_out    out  WIDTH-bit register contents
module shift_left_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_out <= '0;
    end else if (load_en) begin
      q_out <= d_in;
    end else begin
      q_out <= {q_out[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier
//
// Purpose: Multiplies two unsigned DATA_WIDTH-bit operands, one partial product
//          per clock, with a start/busy/done handshake.
// Ports  : clk      in   rising-edge clock
//          reset_n  in   asynchronous active-low reset
//          start    in   request, sampled only while idle
//          a_in     in   multiplicand, captured on the accepting edge
//          b_in     in   multiplier, captured on the accepting edge
//          busy     out  high in LOAD, CALC and DONE
//          done     out  one-cycle completion pulse
//          product  out  2*DATA_WIDTH-bit result, held until the next completion
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a_in,
  input  logic [DATA_WIDTH-1:0]   b_in,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    areg;
  logic [W-1:0]    mreg;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_sum;
  logic [2*W-1:0]  shift_q;
  logic [2*W-1:0]  shift_d;
  logic            load_en;
  logic            last_step;

  // Multiplicand path: loaded in LOAD, then doubled once per CALC step so that
  // step k sees a << k.
  shift_left_register #(
    .WIDTH (2 * W)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .load_en (load_en),
    .d_in    (shift_d),
    .q_out   (shift_q)
  );

  assign shift_d   = {{W{1'b0}}, areg};
  assign acc_sum   = acc + (mreg[0] ? shift_q : '0);
  assign last_step = (cnt == LAST_STEP);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = S_CALC;
      S_CALC:  if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state
  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    load_en = (state == S_LOAD);
  end

  // Datapath: operand capture, accumulation, result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      areg    <= '0;
      mreg    <= '0;
      cnt     <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            areg <= a_in;
            mreg <= b_in;
          end
        end
        S_LOAD: begin
          acc <= '0;
          cnt <= '0;
        end
        S_CALC: begin
          acc  <= acc_sum;
          mreg <= mreg >> 1;
          cnt  <= cnt + CW'(1);
          // The final step's add is folded in directly from acc_sum.
          if (last_step) product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    int             done_cyc;
  } exp_t;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  exp_t           sb[$];
  logic [2*W-1:0] model_prod;
  int             cyc;
  int             n_cmp;
  int             n_bad;

  shift_add_multiplier #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  // Monitor: every falling edge compare busy/done/product with the scoreboard.
  // A request issued with the counter at N must show done at N+W+3; busy is
  // high from its LOAD cycle (W+1 earlier) through DONE.
  initial begin
    logic exp_done;
    logic exp_busy;
    forever begin
      @(negedge clk);
      cyc++;
      exp_done = (sb.size() > 0) && (cyc == sb[0].done_cyc);
      exp_busy = (sb.size() > 0) && (cyc >= sb[0].done_cyc - (W + 1));
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      if (exp_done) begin
        model_prod = sb[0].prod;
        void'(sb.pop_front());
      end
      chk("product", product, model_prod);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) break;
      n++;
      if (n > 200) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  // Issue one request; returns just after the accepting edge with start low
  // and the operand inputs scrambled.
  task automatic issue(input int a, input int b);
    wait_idle();
    a_in  = W'(a);
    b_in  = W'(b);
    start = 1'b1;
    sb.push_back('{prod: ref_mul(a, b), done_cyc: cyc + W + 3});
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
  endtask

  initial begin
    int n0;
    int to;
    cyc        = 0;
    n_cmp      = 0;
    n_bad      = 0;
    model_prod = '0;
    reset_n    = 1'b0;
    start      = 1'b0;
    a_in       = '0;
    b_in       = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Directed patterns, including the upper-half and zero-operand boundaries
    issue(13, 11);
    issue(255, 255);
    issue(0, 200);
    issue(8'h80, 8'h80);
    issue(255, 0);
    issue(1, 1);

    // start held high: back-to-back acceptance in the first idle cycle
    wait_idle();
    a_in  = 8'd3;
    b_in  = 8'd5;
    start = 1'b1;
    n0    = cyc;
    sb.push_back('{prod: ref_mul(3, 5), done_cyc: n0 + W + 3});
    @(posedge clk);
    #1;
    a_in = 8'd7;
    b_in = 8'd9;
    sb.push_back('{prod: ref_mul(7, 9), done_cyc: n0 + 2 * W + 6});
    repeat (W + 3) @(posedge clk);
    #1;
    start = 1'b0;

    // start pulsed mid-CALC with other operands is ignored
    issue(100, 3);
    repeat (3) @(posedge clk);
    #1;
    a_in  = 8'd50;
    b_in  = 8'd60;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Asynchronous reset during CALC
    issue(200, 201);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    sb.delete();
    model_prod = '0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_product", product, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    issue(6, 7);

    // Randomized operands with random idle gaps
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    to = 0;
    while (sb.size() > 0 && to < 300) begin
      @(posedge clk);
      to++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
